// File: rtl/wb_scoreboard_pkg.sv
// Shared defaults, the hardwired-zero register index and the {rd,data} result record
// used by the write-back scoreboard.
package wb_scoreboard_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [WIDTH_DEF-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding long-latency results until the register-file write port is free.
// QDEPTH must be a power of two so the pointers wrap naturally.
module wb_result_fifo #(
    parameter int EW     = 37,
    parameter int QDEPTH = 2
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [EW-1:0]            din,
    output logic [EW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(QDEPTH);

    logic [EW-1:0] mem [QDEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // Storage is data only; a cleared FIFO is defined by its count, not its contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Merges ALU and long-latency results onto the single register-file write port,
// tracks outstanding long destinations and raises the decode stall on hazards.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int width     = WIDTH_DEF,
    parameter int addrWidth = ADDR_W_DEF,
    parameter int QDEPTH    = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [addrWidth-1:0] issue_rd,
    input  logic                 issue_long,
    input  logic [addrWidth-1:0] rs1,
    input  logic [addrWidth-1:0] rs2,
    output logic                 stall,
    input  logic                 alu_valid,
    input  logic [addrWidth-1:0] alu_rd,
    input  logic [width-1:0]     alu_data,
    input  logic                 long_valid,
    input  logic [addrWidth-1:0] long_rd,
    input  logic [width-1:0]     long_data,
    output logic                 long_ready,
    output logic                 regWriteEnable,
    output logic [addrWidth-1:0] addrD,
    output logic [width-1:0]     dataD,
    output logic                 bypA_valid,
    output logic                 bypB_valid,
    output logic [width-1:0]     bypData
);

    localparam int NREG = 2 ** addrWidth;
    localparam int CW   = $clog2(QDEPTH) + 1;
    localparam logic [addrWidth-1:0] ZERO     = addrWidth'(REG_ZERO);
    localparam logic [CW-1:0]        CNT_FULL = CW'(QDEPTH);

    logic [NREG-1:0]            pending;
    logic [NREG-1:0]            pending_nxt;
    logic                       q_full;
    logic                       q_empty;
    logic [CW-1:0]              q_count;
    logic [addrWidth+width-1:0] q_head;
    logic [addrWidth-1:0]       head_rd;
    logic [width-1:0]           head_data;
    logic                       q_push;
    logic                       q_pop;
    logic                       alu_sel;
    logic                       sel_we;
    logic [addrWidth-1:0]       sel_rd;
    logic [width-1:0]           sel_data;
    logic                       issue_set;

    wb_result_fifo #(
        .EW     (addrWidth + width),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (q_push),
        .pop   (q_pop),
        .din   ({long_rd, long_data}),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign {head_rd, head_data} = q_head;

    assign long_ready = !q_full;
    assign q_push     = long_valid && long_ready;

    // The ALU always owns the port; the queue drains only in ALU bubbles.
    assign alu_sel  = alu_valid && (alu_rd != ZERO);
    assign q_pop    = !alu_sel && !q_empty;
    assign sel_we   = alu_sel || (q_pop && (head_rd != ZERO));
    assign sel_rd   = alu_sel ? alu_rd : head_rd;
    assign sel_data = alu_sel ? alu_data : head_data;

    // A full queue stalls decode so the ALU eventually leaves a bubble for it.
    assign stall = pending[rs1] || pending[rs2]
                || (issue_valid && issue_long && pending[issue_rd])
                || (q_count == CNT_FULL);

    assign issue_set = issue_valid && !stall && issue_long && (issue_rd != ZERO);

    always_comb begin
        pending_nxt = pending;
        if (q_pop) begin
            pending_nxt[head_rd] = 1'b0;
        end
        if (issue_set) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pending        <= '0;
            regWriteEnable <= 1'b0;
            addrD          <= '0;
            dataD          <= '0;
        end else begin
            pending        <= pending_nxt;
            regWriteEnable <= sel_we;
            if (sel_we) begin
                addrD <= sel_rd;
                dataD <= sel_data;
            end
        end
    end

    // The register file only shows this write after the next edge, so forward it.
    assign bypA_valid = regWriteEnable && (addrD == rs1) && (rs1 != ZERO);
    assign bypB_valid = regWriteEnable && (addrD == rs2) && (rs2 != ZERO);
    assign bypData    = dataD;

endmodule
